// File: rtl/display_pkg.sv
// Shared raster timing sets and polarity constants.
// Consumed by display_timing_gen and mp3_display.
package display_pkg;

  localparam logic POL_NEG = 1'b0;
  localparam logic POL_POS = 1'b1;

  typedef struct packed {
    int   h_res;
    int   h_fp;
    int   h_sync;
    int   h_bp;
    int   v_res;
    int   v_fp;
    int   v_sync;
    int   v_bp;
    logic h_pol;
    logic v_pol;
  } timing_t;

  localparam timing_t T_640X480 = '{
    h_res: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_res: 480, v_fp: 10, v_sync: 2, v_bp: 33,
    h_pol: POL_NEG, v_pol: POL_NEG
  };

  localparam timing_t T_800X600 = '{
    h_res: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_res: 600, v_fp: 1, v_sync: 4, v_bp: 23,
    h_pol: POL_POS, v_pol: POL_POS
  };

  localparam timing_t T_1280X720 = '{
    h_res: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
    v_res: 720, v_fp: 5, v_sync: 5, v_bp: 20,
    h_pol: POL_POS, v_pol: POL_POS
  };

  // Active area shared with the pixel renderer
  localparam int DISP_H_RES = T_640X480.h_res;
  localparam int DISP_V_RES = T_640X480.v_res;

  // First (most negative) coordinate of a line/frame
  function automatic logic signed [15:0] blank_start(
    input int fp,
    input int sync,
    input int bp
  );
    return 16'(-(fp + sync + bp));
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Clock-enabled shift register for sync/DE alignment.
// DEPTH=0 degenerates to a plain wire.
module sync_delay_line #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = ^{clk, rst, i_ce};
    assign o_q = i_d;
  end else begin : g_pipe
    logic [WIDTH-1:0] pipe_q [DEPTH];
    logic [WIDTH-1:0] pipe_d [DEPTH];

    // Shift one stage per enable tick
    always_comb begin
      pipe_d = pipe_q;
      if (i_ce) begin
        pipe_d[0] = i_d;
        for (int i = 1; i < DEPTH; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end
    end

    // Stage registers, flushed to the inactive vector
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          pipe_q[i] <= RST_VAL;
        end
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign o_q = pipe_q[DEPTH-1];
  end

endmodule

// File: rtl/display_timing_gen.sv
// Raster timing generator: signed x/y, syncs, DE,
// and line/frame strobes.
module display_timing_gen
  import display_pkg::*;
#(
  parameter int H_RES  = T_640X480.h_res,
  parameter int V_RES  = T_640X480.v_res,
  parameter int H_FP   = T_640X480.h_fp,
  parameter int H_SYNC = T_640X480.h_sync,
  parameter int H_BP   = T_640X480.h_bp,
  parameter int V_FP   = T_640X480.v_fp,
  parameter int V_SYNC = T_640X480.v_sync,
  parameter int V_BP   = T_640X480.v_bp,
  parameter bit H_POL  = T_640X480.h_pol,
  parameter bit V_POL  = T_640X480.v_pol,
  parameter int PIPE   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_ce,
  output logic signed [15:0] o_x,
  output logic signed [15:0] o_y,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_de,
  output logic               o_line,
  output logic               o_frame
);

  localparam int H_TOT = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic signed [15:0] H_STA =
    blank_start(H_FP, H_SYNC, H_BP);
  localparam logic signed [15:0] V_STA =
    blank_start(V_FP, V_SYNC, V_BP);
  localparam logic signed [15:0] H_LAST = 16'(H_RES - 1);
  localparam logic signed [15:0] V_LAST = 16'(V_RES - 1);

  // Sync window sits right before the back porch
  localparam logic signed [15:0] HS_BEG = 16'(-(H_SYNC + H_BP));
  localparam logic signed [15:0] HS_END = 16'(-H_BP);
  localparam logic signed [15:0] VS_BEG = 16'(-(V_SYNC + V_BP));
  localparam logic signed [15:0] VS_END = 16'(-V_BP);

  localparam logic [2:0] SYNC_IDLE = {~H_POL, ~V_POL, 1'b0};

  if (H_TOT > 32767 || V_TOT > 32767 ||
      PIPE > 7 || PIPE < 0) begin : g_bad_cfg
    $error("display_timing_gen: illegal timing parameters");
  end

  logic signed [15:0] x_q, x_d;
  logic signed [15:0] y_q, y_d;
  logic               line_q, line_d;
  logic               frame_q, frame_d;
  logic               hs_act, vs_act;
  logic [2:0]         raw_sync;
  logic [2:0]         dly_sync;

  // Next raster position and wrap strobes
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    line_d  = 1'b0;
    frame_d = 1'b0;
    if (i_ce) begin
      if (x_q == H_LAST) begin
        x_d    = H_STA;
        line_d = 1'b1;
        if (y_q == V_LAST) begin
          y_d     = V_STA;
          frame_d = 1'b1;
        end else begin
          y_d = y_q + 16'sd1;
        end
      end else begin
        x_d = x_q + 16'sd1;
      end
    end
  end

  // Position and strobe registers
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= H_STA;
      y_q     <= V_STA;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  // Undelayed sync/DE decoded from the registered position
  always_comb begin
    hs_act   = (x_q >= HS_BEG) && (x_q < HS_END);
    vs_act   = (y_q >= VS_BEG) && (y_q < VS_END);
    raw_sync = {
      hs_act ? H_POL : ~H_POL,
      vs_act ? V_POL : ~V_POL,
      !x_q[15] && !y_q[15]
    };
  end

  sync_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE),
    .RST_VAL (SYNC_IDLE)
  ) u_dly (
    .clk  (clk),
    .rst  (rst),
    .i_ce (i_ce),
    .i_d  (raw_sync),
    .o_q  (dly_sync)
  );

  assign o_x     = x_q;
  assign o_y     = y_q;
  assign o_hsync = dly_sync[2];
  assign o_vsync = dly_sync[1];
  assign o_de    = dly_sync[0];
  assign o_line  = line_q;
  assign o_frame = frame_q;

endmodule

// File: tb/tb_display_timing_gen.sv
// Directed bench: default 640x480 instance (PIPE=0)
// and a tiny raster instance (PIPE=3).
module tb_display_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, ce_a, rst_b, ce_b;

  logic signed [15:0] x_a, y_a, x_b, y_b;
  logic hs_a, vs_a, de_a, line_a, frame_a;
  logic hs_b, vs_b, de_b, line_b, frame_b;

  int total = 0;
  int fails = 0;

  display_timing_gen #(.PIPE(0)) dut_a (
    .clk     (clk),
    .rst     (rst_a),
    .i_ce    (ce_a),
    .o_x     (x_a),
    .o_y     (y_a),
    .o_hsync (hs_a),
    .o_vsync (vs_a),
    .o_de    (de_a),
    .o_line  (line_a),
    .o_frame (frame_a)
  );

  // x: -7..7 (hsync at -5..-3), y: -4..3 (vsync at -3..-2)
  display_timing_gen #(
    .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_RES(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .PIPE(3)
  ) dut_b (
    .clk     (clk),
    .rst     (rst_b),
    .i_ce    (ce_b),
    .o_x     (x_b),
    .o_y     (y_b),
    .o_hsync (hs_b),
    .o_vsync (vs_b),
    .o_de    (de_b),
    .o_line  (line_b),
    .o_frame (frame_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int hist [0:1023];

  initial begin
    int n, hs_low, hs_first, lines, des, vs_low, frames;
    int first_fr, last_fr, prev_x, wrap_k;
    logic prev_de, prev_hs, prev_line;

    rst_a = 1'b1; ce_a = 1'b1;
    rst_b = 1'b1; ce_b = 1'b1;
    tick(); tick();

    // Reset state
    check("a_rst_x", x_a, -160);
    check("a_rst_y", y_a, -45);
    check("a_rst_hs", hs_a, 1);
    check("a_rst_vs", vs_a, 1);
    check("a_rst_de", de_a, 0);
    check("a_rst_line", line_a, 0);
    check("a_rst_frame", frame_a, 0);
    check("b_rst_x", x_b, -7);
    check("b_rst_y", y_b, -4);
    check("b_rst_hs", hs_b, 1);
    check("b_rst_de", de_b, 0);

    // Default timing, one full line with ce steady
    rst_a = 1'b0;
    tick();
    check("a_first_x", x_a, -159);
    hs_low = 0; hs_first = 9999; lines = 0; des = 0;
    wrap_k = -1;
    for (int k = 1; k <= 900; k++) begin
      if (k > 1) tick();
      if (hs_a == 1'b0) begin
        if (hs_low == 0) hs_first = x_a;
        hs_low++;
      end
      if (line_a) lines++;
      if (de_a) des++;
      if (x_a == 16'sd639) begin
        wrap_k = k;
        break;
      end
    end
    check("a_ticks_to_639", wrap_k, 799);
    check("a_hs_low_cnt", hs_low, 96);
    check("a_hs_first_x", hs_first, -144);
    check("a_line_early", lines, 0);
    check("a_de_blank_line", des, 0);
    tick();
    check("a_wrap_x", x_a, -160);
    check("a_wrap_y", y_a, -44);
    check("a_wrap_line", line_a, 1);
    check("a_wrap_frame", frame_a, 0);
    tick();
    check("a_line_width", line_a, 0);
    check("a_post_x", x_a, -159);
    ce_a = 1'b0;
    tick(); tick(); tick();
    check("a_hold_x", x_a, -159);
    check("a_hold_line", line_a, 0);

    // Tiny raster, PIPE=3: frame period, counts, edges
    rst_b = 1'b0;
    hs_low = 0; vs_low = 0; des = 0; lines = 0;
    frames = 0; first_fr = -1; last_fr = -1;
    prev_de = de_b; prev_hs = hs_b;
    for (int t = 1; t <= 240; t++) begin
      tick();
      hist[t] = x_b;
      if (frame_b) begin
        frames++;
        if (first_fr < 0) first_fr = t;
        last_fr = t;
        check("b_frame_implies_line", line_b, 1);
      end
      if (t > 120) begin
        if (!hs_b) hs_low++;
        if (!vs_b) vs_low++;
        if (de_b) des++;
        if (line_b) lines++;
        if (de_b && !prev_de)
          check("b_de_rise_x", hist[t-3], 0);
        if (!de_b && prev_de)
          check("b_de_fall_x", hist[t-3], -7);
        if (!hs_b && prev_hs)
          check("b_hs_fall_x", hist[t-3], -5);
        if (hs_b && !prev_hs)
          check("b_hs_rise_x", hist[t-3], -2);
      end
      prev_de = de_b;
      prev_hs = hs_b;
    end
    check("b_frames", frames, 2);
    check("b_first_frame", first_fr, 120);
    check("b_second_frame", last_fr, 240);
    check("b_hs_low", hs_low, 24);
    check("b_vs_low", vs_low, 30);
    check("b_de_cnt", des, 32);
    check("b_lines", lines, 8);

    // ce one clk in four
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    lines = 0; n = 0;
    prev_line = 1'b0;
    prev_x = x_b;
    for (int k = 0; k < 240; k++) begin
      ce_b = (k % 4 == 0);
      tick();
      if (!ce_b) begin
        if (x_b !== prev_x) check("b_ce_hold_x", x_b, prev_x);
        if (line_b) check("b_ce_low_line", line_b, 0);
      end
      if (line_b) begin
        lines++;
        if (prev_line) n++;
      end
      prev_line = line_b;
      prev_x = x_b;
    end
    check("b_ce4_lines", lines, 4);
    check("b_ce4_wide_line", n, 0);
    check("b_ce4_end_x", x_b, -7);
    check("b_ce4_end_y", y_b, 0);

    // Reset mid-frame while active
    ce_b = 1'b1;
    n = 0;
    while (!(x_b == 16'sd5 && y_b == 16'sd2) && n < 200) begin
      tick();
      n++;
    end
    check("b_reach_mid", n < 200, 1);
    check("b_mid_de", de_b, 1);
    rst_b = 1'b1;
    tick();
    check("b_mrst_x", x_b, -7);
    check("b_mrst_y", y_b, -4);
    check("b_mrst_hs", hs_b, 1);
    check("b_mrst_vs", vs_b, 1);
    check("b_mrst_de", de_b, 0);
    check("b_mrst_frame", frame_b, 0);
    rst_b = 1'b0;
    first_fr = -1;
    for (int t = 1; t <= 200; t++) begin
      tick();
      if (frame_b) begin
        first_fr = t;
        break;
      end
    end
    check("b_mrst_next_frame", first_fr, 120);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
